gpio_in_conditioner: RTL and testbench

Input conditioning stage directly upstream of the 6502 test unit's gpio_i port. It turns raw, asynchronous, bouncy board pins into clean, debounced GPIO input bits. It also produces per-bit rise/fall event pulses and a sticky "changed" flag for software polling. It runs in the 12 MHz CPU clock domain and replaces the constant-zero tie-off on gpio_i.

---
 rtl/gpio_in_conditioner_pkg.sv | 12 +
 rtl/gpio_in_conditioner_if.sv | 29 ++
 rtl/gpio_in_conditioner_debounce_bit.sv | 71 +++++++
 rtl/gpio_in_conditioner.sv | 29 ++
 tb/tb_gpio_in_conditioner.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/gpio_in_conditioner_pkg.sv
// Shared constants and helpers for the GPIO input conditioning slice.
package gpio_pkg;

   localparam int GPIO_WIDTH         = 8;
   localparam int DEBOUNCE_1MS_12MHZ = 12000;

   // Counter must hold values up to and including the debounce length.
   function automatic int cnt_width(input int debounce_cycles);
      return $clog2(debounce_cycles + 1);
   endfunction

endpackage

// File: rtl/gpio_in_conditioner_if.sv
// Pin-side and CPU-side GPIO bundle; slave is the conditioner, master the consumer/board.
interface gpio_in_conditioner_if #(
   parameter int WIDTH = gpio_pkg::GPIO_WIDTH
);
   logic [WIDTH-1:0] pins_i;
   logic [WIDTH-1:0] gpio_i;
   logic [WIDTH-1:0] rise_o;
   logic [WIDTH-1:0] fall_o;
   logic [WIDTH-1:0] changed_o;
   logic [WIDTH-1:0] ack_i;

   modport slave (
      input  pins_i,
      input  ack_i,
      output gpio_i,
      output rise_o,
      output fall_o,
      output changed_o
   );

   modport master (
      output pins_i,
      output ack_i,
      input  gpio_i,
      input  rise_o,
      input  fall_o,
      input  changed_o
   );
endinterface

// File: rtl/gpio_in_conditioner_debounce_bit.sv
// Single-bit conditioner: 2-flop synchroniser, stability counter, edge pulses, sticky flag.
module gpio_debounce_bit
   import gpio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_12MHZ
) (
   input  logic clk,
   input  logic reset,
   input  logic pin_i,
   input  logic ack_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic changed_o
);

   localparam int               CNT_W  = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q, s2_q;
   logic             stable_q, stable_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             changed_q, changed_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      if (s2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_TC) begin
         stable_d = s2_q;
         cnt_d    = '0;
         rise_d   = s2_q;
         fall_d   = ~s2_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      // A new event outranks a simultaneous acknowledge so it is never lost.
      changed_d = rise_d | fall_d | (changed_q & ~ack_i);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         stable_q  <= 1'b0;
         cnt_q     <= '0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         s1_q      <= pin_i;
         s2_q      <= s1_q;
         stable_q  <= stable_d;
         cnt_q     <= cnt_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         changed_q <= changed_d;
      end
   end

   assign level_o   = stable_q;
   assign rise_o    = rise_q;
   assign fall_o    = fall_q;
   assign changed_o = changed_q;

endmodule

// File: rtl/gpio_in_conditioner.sv
// Debounces raw board pins into the 6502 unit's gpio_i, with per-bit edge events and sticky change flags.
module gpio_in_conditioner
   import gpio_pkg::*;
#(
   parameter int WIDTH           = GPIO_WIDTH,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_12MHZ
) (
   input  logic                  clk,
   input  logic                  reset,
   gpio_in_conditioner_if.slave  bus
);

   // Bits share nothing but the clock and reset.
   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      gpio_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
         .clk       (clk),
         .reset     (reset),
         .pin_i     (bus.pins_i[g]),
         .ack_i     (bus.ack_i[g]),
         .level_o   (bus.gpio_i[g]),
         .rise_o    (bus.rise_o[g]),
         .fall_o    (bus.fall_o[g]),
         .changed_o (bus.changed_o[g])
      );
   end

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed plus randomized bench for gpio_in_conditioner against a sample-window reference model.
module tb_gpio_in_conditioner;

   localparam int W = 8;
   localparam int D = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   gpio_in_conditioner_if #(.WIDTH(W)) bus ();

   gpio_in_conditioner #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Model: history of pin samples, one per edge; a bit flips once the D samples
   // seen through the two-flop delay all disagree with the current level.
   logic [W-1:0] hist[$];
   logic [W-1:0] m_gpio, m_rise, m_fall, m_chg;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic rst_n, input logic [W-1:0] pins, input logic [W-1:0] ack);
      bit agree;
      if (!rst_n) begin
         hist.delete();
         for (int i = 0; i < D + 2; i++) hist.push_back('0);
         m_gpio = '0; m_rise = '0; m_fall = '0; m_chg = '0;
      end else begin
         hist.push_back(pins);
         void'(hist.pop_front());
         m_rise = '0;
         m_fall = '0;
         for (int b = 0; b < W; b++) begin
            agree = 1'b1;
            for (int j = 0; j < D; j++)
               if (hist[j][b] == m_gpio[b]) agree = 1'b0;
            if (agree) begin
               m_gpio[b] = ~m_gpio[b];
               if (m_gpio[b]) m_rise[b] = 1'b1;
               else           m_fall[b] = 1'b1;
            end
         end
         m_chg = m_rise | m_fall | (m_chg & ~ack);
      end
   endtask

   task automatic step(input logic rst_n, input logic [W-1:0] pins, input logic [W-1:0] ack);
      reset      = rst_n;
      bus.pins_i = pins;
      bus.ack_i  = ack;
      @(posedge clk);
      model_edge(rst_n, pins, ack);
      #1;
      check("gpio",    bus.gpio_i,    m_gpio);
      check("rise",    bus.rise_o,    m_rise);
      check("fall",    bus.fall_o,    m_fall);
      check("changed", bus.changed_o, m_chg);
   endtask

   int           rise7;
   logic [W-1:0] pins_r;

   initial begin
      reset      = 1'b0;
      bus.pins_i = '0;
      bus.ack_i  = '0;
      #2;

      // Reset with pins high, then release: rise on the 6th edge.
      for (int i = 0; i < 3; i++) step(1'b0, 8'hFF, 8'h00);
      check("rst_gpio", bus.gpio_i, 8'h00);
      check("rst_chg",  bus.changed_o, 8'h00);
      for (int i = 0; i < 5; i++) step(1'b1, 8'hFF, 8'h00);
      check("pre_rise_gpio", bus.gpio_i, 8'h00);
      step(1'b1, 8'hFF, 8'h00);
      check("edge6_gpio", bus.gpio_i, 8'hFF);
      check("edge6_rise", bus.rise_o, 8'hFF);
      check("edge6_chg",  bus.changed_o, 8'hFF);
      step(1'b1, 8'hFF, 8'h00);
      check("rise_one_cycle", bus.rise_o, 8'h00);

      // Return to zero; acknowledge throughout so set-wins then clear is exercised.
      for (int i = 0; i < 8; i++) step(1'b1, 8'h00, 8'hFF);
      check("zero_chg", bus.changed_o, 8'h00);

      // Short pulse rejected, then a held level accepted after 6 edges.
      for (int i = 0; i < 3; i++) step(1'b1, 8'h01, 8'h00);
      for (int i = 0; i < 4; i++) step(1'b1, 8'h00, 8'h00);
      check("glitch_gpio", bus.gpio_i, 8'h00);
      for (int i = 0; i < 5; i++) step(1'b1, 8'h01, 8'h00);
      check("hold5_gpio", bus.gpio_i, 8'h00);
      step(1'b1, 8'h01, 8'h00);
      check("hold6_gpio", bus.gpio_i, 8'h01);

      // Fall, then a single ack clears the flag.
      for (int i = 0; i < 6; i++) step(1'b1, 8'h00, 8'h00);
      check("fall_pulse", bus.fall_o, 8'h01);
      check("fall_chg",   bus.changed_o, 8'h01);
      step(1'b1, 8'h00, 8'h01);
      check("ack_clear", bus.changed_o, 8'h00);
      step(1'b1, 8'h00, 8'h01);

      // Ack on the very edge bit 3 transitions.
      for (int i = 0; i < 5; i++) step(1'b1, 8'h08, 8'h00);
      step(1'b1, 8'h08, 8'h08);
      check("ack_collide", bus.changed_o & 8'h08, 8'h08);

      // Reset in the middle of bit 5's debounce restarts the full count.
      for (int i = 0; i < 5; i++) step(1'b1, 8'h28, 8'h00);
      step(1'b0, 8'h28, 8'h00);
      check("mid_rst_gpio", bus.gpio_i, 8'h00);
      for (int i = 0; i < 5; i++) step(1'b1, 8'h28, 8'h00);
      check("mid_rst_hold5", bus.gpio_i, 8'h00);
      step(1'b1, 8'h28, 8'h00);
      check("mid_rst_hold6", bus.gpio_i, 8'h28);

      // Bounce burst on bit 7, then settle high: exactly one rise.
      rise7 = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 8'h28 | (i[0] ? 8'h80 : 8'h00), 8'h00);
         if (bus.rise_o[7]) rise7++;
      end
      check("burst_rise7", 8'(rise7), 8'h00);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 8'hA8, 8'h00);
         if (bus.rise_o[7]) rise7++;
      end
      check("settle_rise7", 8'(rise7), 8'h01);

      // Randomized: slowly changing pins with occasional glitches, acks and resets.
      pins_r = 8'hA8;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 5) == 0) pins_r = pins_r ^ 8'($urandom);
         step(($urandom_range(0, 150) != 0), pins_r, 8'($urandom) & 8'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
